logic_op_scheduler: RTL and testbench

- Round-robin arbiter and sequencer that shares one registered 2-input bitwise logic unit (AND/OR/XOR/NAND, W bits wide) among NREQ requesters.
- Each requester presents an opcode and two operands and holds a request.
- The scheduler grants one requester, latches its operands, executes, then returns the result with the requester ID and a one-cycle ack.
- Sits between client blocks and the shared gate datapath; the gate primitives are the datapath it sequences.

---
 rtl/logic_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/logic_op_scheduler.sv | 152 +++++++++++++++
 tb/tb_logic_op_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_sched_pkg.sv
// Shared constants for the logic-op scheduler: opcode encodings, FSM state codes and id sizing.
package logic_sched_pkg;

    typedef logic [1:0] opcode_t;
    typedef logic [1:0] sched_state_t;

    localparam opcode_t OP_AND  = 2'b00;
    localparam opcode_t OP_OR   = 2'b01;
    localparam opcode_t OP_XOR  = 2'b10;
    localparam opcode_t OP_NAND = 2'b11;

    localparam sched_state_t IDLE = 2'd0;
    localparam sched_state_t EXEC = 2'd1;
    localparam sched_state_t RESP = 2'd2;

    // A single requester still needs a one-bit id field.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, else wrap to the lowest one.
module rr_arbiter
    import logic_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant,
    output logic            any_req
);

    logic           hit_hi;
    logic           hit_lo;
    logic [IDW-1:0] gnt_hi;
    logic [IDW-1:0] gnt_lo;

    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        gnt_hi = '0;
        gnt_lo = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!hit_hi && req[j] && (IDW'(j) >= ptr)) begin
                hit_hi = 1'b1;
                gnt_hi = IDW'(j);
            end
            if (!hit_lo && req[j]) begin
                hit_lo = 1'b1;
                gnt_lo = IDW'(j);
            end
        end
        any_req = |req;
        grant   = hit_hi ? gnt_hi : gnt_lo;
    end

endmodule

// File: rtl/logic_op_scheduler.sv
// Shares one registered bitwise logic unit among NREQ requesters (IDLE -> EXEC -> RESP).
// Define LOGIC_SCHED_OPCOUNT_EN to add the completed-operation counter output op_count.
module logic_op_scheduler
    import logic_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int CNT_W = 16,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    input  logic [W*NREQ-1:0] a,
    input  logic [W*NREQ-1:0] b,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      result,
    output logic [IDW-1:0]    result_id,
    output logic              result_valid,
    output logic              busy
`ifdef LOGIC_SCHED_OPCOUNT_EN
    ,
    output logic [CNT_W-1:0]  op_count
`endif
);

    sched_state_t   state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_q;
    opcode_t        op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;

    logic [IDW-1:0]  grant;
    logic            any_req;
    opcode_t         sel_op;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [W-1:0]    alu_out;
    logic [NREQ-1:0] ack_d;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .grant  (grant),
        .any_req(any_req)
    );

    always_comb begin
        sel_op = OP_AND;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_op = op[2*i +: 2];
                sel_a  = a[W*i +: W];
                sel_b  = b[W*i +: W];
            end
        end
    end

    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_AND:  alu_out = a_q & b_q;
            OP_OR:   alu_out = a_q | b_q;
            OP_XOR:  alu_out = a_q ^ b_q;
            OP_NAND: alu_out = ~(a_q & b_q);
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        ack_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IDW'(i)) begin
                ack_d[i] = 1'b1;
            end
        end
    end

    assign busy = (state == EXEC) || (state == RESP);

    // ack/result_valid are registered on the EXEC->RESP edge so they line up with the RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_q      <= '0;
            op_q         <= OP_AND;
            a_q          <= '0;
            b_q          <= '0;
            ack          <= '0;
            result       <= '0;
            result_id    <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack          <= '0;
                    result_valid <= 1'b0;
                    if (any_req) begin
                        grant_q <= grant;
                        op_q    <= sel_op;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    result       <= alu_out;
                    result_id    <= grant_q;
                    ack          <= ack_d;
                    result_valid <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    ack          <= '0;
                    result_valid <= 1'b0;
                    if (grant_q == IDW'(NREQ - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= grant_q + 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    ack          <= '0;
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef LOGIC_SCHED_OPCOUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (state == RESP) begin
            op_count <= op_count + 1'b1;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Scoreboard bench for logic_op_scheduler; expected results are queued at drive time.
module tb_logic_op_scheduler;

    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op;
    logic [W*NREQ-1:0] a;
    logic [W*NREQ-1:0] b;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      result;
    logic [1:0]        result_id;
    logic              result_valid;
    logic              busy;
`ifdef LOGIC_SCHED_OPCOUNT_EN
    logic [CNT_W-1:0]  op_count;
`endif

    typedef struct {
        logic [W-1:0] res;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   ops_done = 0;
    int   rr_model = 0;
    bit   mon_en   = 1'b0;

    logic_op_scheduler #(
        .NREQ (NREQ),
        .W    (W),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op          (op),
        .a           (a),
        .b           (b),
        .ack         (ack),
        .result      (result),
        .result_id   (result_id),
        .result_valid(result_valid),
        .busy        (busy)
`ifdef LOGIC_SCHED_OPCOUNT_EN
        ,
        .op_count    (op_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    task automatic set_lane(input int i, input logic [1:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y);
        op[2*i +: 2] = o;
        a[W*i +: W]  = x;
        b[W*i +: W]  = y;
    endtask

    task automatic check_count();
`ifdef LOGIC_SCHED_OPCOUNT_EN
        check("op_count", op_count, ops_done % (1 << CNT_W));
`endif
    endtask

    task automatic check_all_zero();
        check("zero_ack", ack, 0);
        check("zero_result", result, 0);
        check("zero_result_id", result_id, 0);
        check("zero_result_valid", result_valid, 0);
        check("zero_busy", busy, 0);
        check_count();
    endtask

    // Single isolated operation; assumes the DUT is idle when called.
    task automatic do_op(input int i, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        int           waited;
        logic [W-1:0] r;
        r = model(o, x, y);
        set_lane(i, o, x, y);
        sb.push_back('{r, i});
        req[i] = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ack[i] && waited < 10);
        check("ack_seen", ack[i], 1);
        check("latency", waited, 2);
        req[i]   = 1'b0;
        ops_done++;
        rr_model = (i + 1) % NREQ;
        @(negedge clk);
        check("result_held", result, r);
        check("busy_after", busy, 0);
        check_count();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (result_valid) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("result_id", result_id, e.id);
                    check("ack_onehot", ack, 1 << e.id);
                end
            end else begin
                check("ack_idle", ack, 0);
            end
        end
    end

    initial begin
        int           waited;
        int           acks;
        logic [3:0]   dropped;
        logic [W-1:0] fa;
        logic [W-1:0] fb;

        rst = 1'b1;
        req = '0;
        op  = '0;
        a   = '0;
        b   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset while requester 2 is in EXEC: the op must vanish without an ack.
        set_lane(2, 2'b10, 8'h5A, 8'hFF);
        req[2] = 1'b1;
        @(negedge clk);
        check("busy_exec", busy, 1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        ops_done = 0;
        rr_model = 0;
        check_all_zero();
        rst = 1'b0;

        do_op(0, 2'b00, 8'hF0, 8'h3C);

        for (int o = 0; o < 4; o++) begin
            do_op(1, 2'(o), 8'hAA, 8'h0F);
        end

        // Operand A changes under an in-flight AND; latched value must be used.
        set_lane(0, 2'b00, 8'hFF, 8'h0F);
        sb.push_back('{8'h0F, 0});
        req[0] = 1'b1;
        @(negedge clk);
        a[W-1:0] = 8'h00;
        req[0]   = 1'b0;
        waited   = 1;
        while (!ack[0] && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("chg_ack_seen", ack[0], 1);
        ops_done++;
        rr_model = 1;
        @(negedge clk);
        check_count();

        // All four requesters contend; expect strict rotation from the current pointer.
        for (int i = 0; i < NREQ; i++) begin
            fa = W'(8'h11 * (i + 1));
            fb = W'(8'h3C + i);
            set_lane(i, 2'(i), fa, fb);
        end
        for (int k = 0; k < 2 * NREQ; k++) begin
            int id;
            id = (rr_model + k) % NREQ;
            sb.push_back('{model(2'(id), W'(8'h11 * (id + 1)), W'(8'h3C + id)), id});
        end
        req     = 4'hF;
        acks    = 0;
        waited  = 0;
        dropped = '0;
        while (acks < 2 * NREQ && waited < 80) begin
            @(negedge clk);
            waited++;
            req     = req | dropped;
            dropped = '0;
            if (ack != 0) begin
                acks++;
                if (acks == 2 * NREQ) begin
                    req = '0;
                end else begin
                    req     = req & ~ack;
                    dropped = ack;
                end
            end
        end
        req = '0;
        check("fair_acks", acks, 2 * NREQ);
        ops_done += 2 * NREQ;
        @(negedge clk);
        check_count();

        for (int k = 0; k < 6; k++) begin
            do_op(int'($urandom_range(0, NREQ - 1)), 2'($urandom_range(0, 3)), W'($urandom),
                  W'($urandom));
        end

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
